// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: reset PC default, major opcodes and the
// fetch FSM state encoding used by instruction_fetch.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter flop for the fetch stage: holds, advances by one word, or
// loads a redirect target with the byte offset bits cleared.
module pc_register #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    // Redirect wins over sequential advance; the increment wraps naturally.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc & ~ADDR_W'(3);
        end else if (advance) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: one outstanding imem read, IF/ID register with stall and
// branch redirect/kill. Define IFETCH_PERF_EN to build the delivered-instruction counter.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [5:0]        if_opcode,
    output logic [ADDR_W-1:0] if_pc4,
    output logic [31:0]       fetch_count
);

    fetch_state_t      state_q, state_d;
    logic              kill_q, kill_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0] if_pc4_q, if_pc4_d;

    logic              accept;
    logic              rsp_land;
    logic              deliver;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;

    assign accept   = imem_req_valid && imem_req_ready;
    assign rsp_land = (state_q == WAIT) && imem_rsp_valid;
    assign deliver  = rsp_land && !kill_q && !branch_taken;

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .redirect    (branch_taken),
        .redirect_pc (branch_target),
        .advance     (deliver),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ:     if (accept)   state_d = WAIT;
            WAIT:    if (rsp_land) state_d = REQ;
            default: state_d = REQ;
        endcase
    end

    // No request while reset is held or while decode is holding a valid word.
    always_comb begin
        imem_req_valid = !rst && (state_q == REQ) && !(if_valid_q && stall);
        imem_addr      = pc;
    end

    // A branch marks the in-flight read as dead unless it returns this very cycle.
    always_comb begin
        kill_d = kill_q;
        if (branch_taken) begin
            if (state_q == WAIT) begin
                kill_d = !imem_rsp_valid;
            end else if (accept) begin
                kill_d = 1'b1;
            end
        end else if (rsp_land) begin
            kill_d = 1'b0;
        end
    end

    always_comb begin
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc4_d   = if_pc4_q;
        if (branch_taken) begin
            if_valid_d = 1'b0;
        end else if (deliver) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rsp_data;
            if_pc4_d   = pc_plus4;
        end else if (if_valid_q && !stall) begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kill_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc4_q   <= '0;
        end else begin
            kill_q     <= kill_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc4_q   <= if_pc4_d;
        end
    end

    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_opcode = opcode_of(32'(if_instr_q));
    assign if_pc4    = if_pc4_q;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (deliver) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a cycle table for basic fetch/stall
// behaviour plus hand sequences for latency, branch kill, wrap and reset.
module tb_instruction_fetch;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [5:0]  if_opcode;
    logic [31:0] if_pc4;
    logic [31:0] fetch_count;

    int tests_run = 0;
    int tests_failed = 0;

    int          lat = 1;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    bit          last_acc = 1'b0;
    logic [31:0] last_acc_addr = '0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_opcode      (if_opcode),
        .if_pc4         (if_pc4),
        .fetch_count    (fetch_count)
    );

    typedef struct {
        logic        stall;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h8C22_0004 : 32'h1000_0000 + a;
    endfunction

    function automatic logic [31:0] exp_count(input int n);
`ifdef IFETCH_PERF_EN
        return 32'(n);
`else
        return 32'(0 * n);
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: timed out waiting on DUT, expected event within bound", name);
    endtask

    // One clock: sample the request before the edge, then advance the memory model.
    task automatic tick();
        bit          acc;
        logic [31:0] a;
        #1;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_addr;
        if (acc) checkOutput("one_outstanding", 32'(pend), 32'h0);
        @(posedge clk);
        #1;
        last_acc       = acc;
        last_acc_addr  = a;
        imem_rsp_valid = 1'b0;
        if (acc) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = a;
        end
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(paddr);
                pend           = 1'b0;
            end
        end
    endtask

    task automatic resetDut();
        rst            = 1'b1;
        stall          = 1'b0;
        branch_taken   = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        pend           = 1'b0;
        last_acc       = 1'b0;
        #2;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("rst_if_valid", 32'(if_valid), 32'h0);
        checkOutput("rst_if_instr", if_instr, 32'h0);
        checkOutput("rst_if_pc4", if_pc4, 32'h0);
        checkOutput("rst_addr", imem_addr, RESET_PC_DEFAULT);
        checkOutput("rst_fetch_count", fetch_count, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        stall        = v.stall;
        branch_taken = 1'b0;
    endtask

    task automatic runUntilAccept(input string name, output logic [31:0] addr);
        addr = 'x;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (last_acc) begin
                addr = last_acc_addr;
                return;
            end
        end
        reportTimeout(name);
    endtask

    task automatic runUntilValid(input string name, output int n);
        n = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (if_valid === 1'b1) begin
                n = k;
                return;
            end
        end
        reportTimeout(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          n;

        vecs[0]  = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h4, 1'b1, 32'h8C22_0004, 32'h4};
        vecs[3]  = '{1'b0, 1'b0, 32'h4, 1'b0, 32'h8C22_0004, 32'h4};
        for (int i = 4; i <= 8; i++) begin
            vecs[i] = '{1'b1, 1'b0, 32'h8, 1'b1, 32'h1000_0004, 32'h8};
        end
        vecs[9]  = '{1'b0, 1'b1, 32'h8, 1'b1, 32'h1000_0004, 32'h8};
        vecs[10] = '{1'b0, 1'b0, 32'h8, 1'b0, 32'h1000_0004, 32'h8};
        vecs[11] = '{1'b0, 1'b1, 32'hC, 1'b1, 32'h1000_0008, 32'hC};

        #1;
        // Basic fetch with 1-cycle memory, then a 5-cycle stall and resume.
        lat = 1;
        resetDut();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            #2;
            checkOutput($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_req));
            checkOutput($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            checkOutput($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].e_valid));
            checkOutput($sformatf("v%0d_if_instr", i), if_instr, vecs[i].e_instr);
            checkOutput($sformatf("v%0d_if_opcode", i), 32'(if_opcode), 32'(vecs[i].e_instr[31:26]));
            checkOutput($sformatf("v%0d_if_pc4", i), if_pc4, vecs[i].e_pc4);
            tick();
        end
        checkOutput("v_fetch_count", fetch_count, exp_count(3));
        stall = 1'b0;

        // Latency-3 memory: sequential addresses, one in flight, if_valid 3 cycles after accept.
        resetDut();
        lat = 3;
        for (int k = 0; k < 4; k++) begin
            runUntilAccept($sformatf("t2_accept%0d", k), a);
            checkOutput($sformatf("t2_addr%0d", k), a, 32'(4 * k));
        end
        runUntilValid("t2_valid", n);
        checkOutput("t2_latency", 32'(n), 32'd3);
        checkOutput("t2_instr", if_instr, 32'h1000_000C);
        checkOutput("t2_pc4", if_pc4, 32'h10);

        // Branch while waiting on addr 8: that response is dropped.
        resetDut();
        lat = 3;
        runUntilAccept("t4_acc0", a);
        runUntilAccept("t4_acc4", a);
        runUntilAccept("t4_acc8", a);
        checkOutput("t4_addr8", a, 32'h8);
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0043;
        tick();
        branch_taken = 1'b0;
        checkOutput("t4_valid_after_branch", 32'(if_valid), 32'h0);
        checkOutput("t4_redirect_addr", imem_addr, 32'h0000_0040);
        runUntilAccept("t4_acc40", a);
        checkOutput("t4_addr40", a, 32'h0000_0040);
        checkOutput("t4_valid_killed", 32'(if_valid), 32'h0);
        runUntilValid("t4_valid40", n);
        checkOutput("t4_instr40", if_instr, 32'h1000_0040);
        checkOutput("t4_pc4_40", if_pc4, 32'h0000_0044);
        checkOutput("t4_fetch_count", fetch_count, exp_count(3));

        // Retarget an unaccepted request to the top word, wrap, then branch on a landing response.
        resetDut();
        lat = 2;
        imem_req_ready = 1'b0;
        branch_taken   = 1'b1;
        branch_target  = 32'hFFFF_FFFF;
        tick();
        branch_taken = 1'b0;
        checkOutput("t5_retarget_addr", imem_addr, 32'hFFFF_FFFC);
        checkOutput("t5_retarget_req", 32'(imem_req_valid), 32'h1);
        imem_req_ready = 1'b1;
        runUntilAccept("t5_acc_top", a);
        checkOutput("t5_addr_top", a, 32'hFFFF_FFFC);
        runUntilValid("t5_valid_top", n);
        checkOutput("t5_instr_top", if_instr, 32'h0FFF_FFFC);
        checkOutput("t5_pc4_wrap", if_pc4, 32'h0);
        runUntilAccept("t5_acc_wrap", a);
        checkOutput("t5_addr_wrap", a, 32'h0);
        for (int k = 0; k < 10 && !imem_rsp_valid; k++) tick();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0100;
        tick();
        branch_taken = 1'b0;
        checkOutput("t5_valid_dropped", 32'(if_valid), 32'h0);
        checkOutput("t5_redirect_addr", imem_addr, 32'h0000_0100);
        runUntilAccept("t5_acc100", a);
        checkOutput("t5_addr100", a, 32'h0000_0100);
        runUntilValid("t5_valid100", n);
        checkOutput("t5_instr100", if_instr, 32'h1000_0100);
        checkOutput("t5_pc4_100", if_pc4, 32'h0000_0104);

        // Reset pulse while waiting: the late response must be ignored.
        resetDut();
        lat = 3;
        runUntilAccept("t6_acc0", a);
        imem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("t6_req_in_reset", 32'(imem_req_valid), 32'h0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("t6_valid%0d", k), 32'(if_valid), 32'h0);
            checkOutput($sformatf("t6_addr%0d", k), imem_addr, RESET_PC_DEFAULT);
        end
        checkOutput("t6_req_state", 32'(imem_req_valid), 32'h1);
        checkOutput("t6_fetch_count0", fetch_count, 32'h0);
        imem_req_ready = 1'b1;
        runUntilAccept("t6_acc_again", a);
        checkOutput("t6_addr_again", a, 32'h0);
        runUntilValid("t6_valid_again", n);
        checkOutput("t6_instr", if_instr, 32'h8C22_0004);
        checkOutput("t6_opcode", 32'(if_opcode), 32'(OP_LW));
        checkOutput("t6_fetch_count1", fetch_count, exp_count(1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
